csr_unit: RTL and testbench

Machine-mode control/status register unit for the RV32 core: performs CSRRW/CSRRS/CSRRC read-modify-write with legality checking, keeps 64-bit cycle/instret counters, and sequences trap entry and mret through a small redirect FSM. Sits beside the execute stage; rdata feeds writeback, redirect_* feeds the fetch PC mux.

---
 rtl/csr_addr_pkg.sv | 37 +++
 rtl/type_pkg.sv | 5 +
 rtl/csr_counter64.sv | 31 +++
 rtl/csr_unit.sv | 193 +++++++++++++++++++
 tb/tb_csr_unit.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_addr_pkg.sv
// Machine-mode CSR addresses, operation encoding and fixed register fields.
package csr_addr_pkg;
  typedef enum logic [1:0] {
    CsrNone = 2'd0,
    CsrRw   = 2'd1,
    CsrRs   = 2'd2,
    CsrRc   = 2'd3
  } csr_op_t;

  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMie       = 12'h304;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMtval     = 12'h343;
  localparam logic [11:0] CsrMip       = 12'h344;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;
  localparam logic [31:0] MisaValue      = 32'h4000_0100;

  // MPP is hardwired to machine mode; only MIE/MPIE are live.
  function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
    logic [31:0] v;
    v = 32'h0000_1800;
    v[MstatusMieBit]  = mie;
    v[MstatusMpieBit] = mpie;
    return v;
  endfunction
endpackage

// File: rtl/type_pkg.sv
// Shared datapath types for the RV32 core.
package type_pkg;
  localparam int unsigned Xlen = 32;
  typedef logic [Xlen-1:0] data_t;
endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter; a write to either half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_lo_o,
  output logic [31:0] rdata_hi_o
);
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rdata_lo_o = cnt_q[31:0];
  assign rdata_hi_o = cnt_q[63:32];
endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: read-modify-write, trap entry / mret redirect FSM.
// Define CSR_COUNTERS_EN to implement mcycle/minstret; otherwise they read 0.
module csr_unit
  import type_pkg::*;
  import csr_addr_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter logic [31:0] HART_ID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  input  csr_op_t         csr_op_i,
  input  logic            src_zero_i,
  input  logic [11:0]     addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o,
  output logic            illegal_o,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            retire_i,
  output logic            busy_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);
  typedef enum logic [0:0] {StIdle, StRedirect} state_e;

  state_e      state_q, state_d;
  data_t       target_q, target_d;
  logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  data_t       mie_q, mie_d, mscratch_q, mscratch_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [29:0] mtvec_q, mtvec_d, mepc_q, mepc_d;

  data_t old_val, new_val;
  logic  implemented, write_req, illegal, csr_we, idle;

`ifdef CSR_COUNTERS_EN
  logic [31:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
`endif

  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (addr_i)
      CsrMstatus:   old_val = mstatus_pack(mst_mie_q, mst_mpie_q);
      CsrMisa:      old_val = MisaValue;
      CsrMie:       old_val = mie_q;
      CsrMtvec:     old_val = {mtvec_q, 2'b00};
      CsrMscratch:  old_val = mscratch_q;
      CsrMepc:      old_val = {mepc_q, 2'b00};
      CsrMcause:    old_val = mcause_q;
      CsrMtval:     old_val = mtval_q;
      CsrMip:       old_val = '0;
      CsrMhartid:   old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      CsrMcycle:    old_val = mcycle_lo;
      CsrMcycleh:   old_val = mcycle_hi;
      CsrMinstret:  old_val = minstret_lo;
      CsrMinstreth: old_val = minstret_hi;
`else
      CsrMcycle, CsrMcycleh, CsrMinstret, CsrMinstreth: old_val = '0;
`endif
      default:      implemented = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op_i)
      CsrRw:   new_val = wdata_i;
      CsrRs:   new_val = old_val | wdata_i;
      CsrRc:   new_val = old_val & ~wdata_i;
      default: new_val = old_val;
    endcase
  end

  assign write_req = (csr_op_i == CsrRw) ||
                     (((csr_op_i == CsrRs) || (csr_op_i == CsrRc)) && !src_zero_i);
  assign illegal   = req_valid_i && (!implemented || (write_req && (addr_i[11:10] == 2'b11)));
  assign idle      = (state_q == StIdle);
  // Traps and mret pre-empt any CSR write in the same cycle.
  assign csr_we    = req_valid_i && write_req && !illegal && idle && !trap_valid_i && !mret_i;

  assign rdata_o   = illegal ? '0 : old_val;
  assign illegal_o = illegal;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (!idle) begin
      state_d = StIdle;
    end else if (trap_valid_i) begin
      mepc_d     = trap_pc_i[31:2];
      mcause_d   = trap_cause_i;
      mtval_d    = trap_tval_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
      target_d   = {mtvec_q, 2'b00};
      state_d    = StRedirect;
    end else if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
      target_d   = {mepc_q, 2'b00};
      state_d    = StRedirect;
    end else if (csr_we) begin
      case (addr_i)
        CsrMstatus: begin
          mst_mie_d  = new_val[MstatusMieBit];
          mst_mpie_d = new_val[MstatusMpieBit];
        end
        CsrMie:      mie_d      = new_val;
        CsrMtvec:    mtvec_d    = new_val[31:2];
        CsrMscratch: mscratch_d = new_val;
        CsrMepc:     mepc_d     = new_val[31:2];
        CsrMcause:   mcause_d   = new_val;
        CsrMtval:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      target_q   <= '0;
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET[31:2];
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 u_mcycle (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (1'b1),
    .wr_lo_i    (csr_we && (addr_i == CsrMcycle)),
    .wr_hi_i    (csr_we && (addr_i == CsrMcycleh)),
    .wdata_i    (new_val),
    .rdata_lo_o (mcycle_lo),
    .rdata_hi_o (mcycle_hi)
  );

  csr_counter64 u_minstret (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (retire_i),
    .wr_lo_i    (csr_we && (addr_i == CsrMinstret)),
    .wr_hi_i    (csr_we && (addr_i == CsrMinstreth)),
    .wdata_i    (new_val),
    .rdata_lo_o (minstret_lo),
    .rdata_hi_o (minstret_hi)
  );
`else
  logic unused_retire;
  assign unused_retire = retire_i;
`endif

  assign busy_o           = (state_q == StRedirect);
  assign redirect_valid_o = (state_q == StRedirect);
  assign redirect_pc_o    = target_q;
  assign mtvec_o          = {mtvec_q, 2'b00};
  assign mepc_o           = {mepc_q, 2'b00};
endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: vector table plus trap/mret/counter sequences.
module tb_csr_unit;
  import csr_addr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, src_zero, trap_valid, mret, retire;
  csr_op_t     csr_op;
  logic [11:0] addr;
  logic [31:0] wdata, trap_cause, trap_pc, trap_tval;
  logic [31:0] rdata, redirect_pc, mtvec, mepc;
  logic        illegal, busy, redirect_valid;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  csr_unit #(
    .XLEN        (32),
    .HART_ID     (32'h0000_0005),
    .MTVEC_RESET (32'h0000_0203)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .csr_op_i         (csr_op),
    .src_zero_i       (src_zero),
    .addr_i           (addr),
    .wdata_i          (wdata),
    .rdata_o          (rdata),
    .illegal_o        (illegal),
    .trap_valid_i     (trap_valid),
    .trap_cause_i     (trap_cause),
    .trap_pc_i        (trap_pc),
    .trap_tval_i      (trap_tval),
    .mret_i           (mret),
    .retire_i         (retire),
    .busy_o           (busy),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .mtvec_o          (mtvec),
    .mepc_o           (mepc)
  );

  typedef struct {
    csr_op_t     op;
    logic [11:0] a;
    logic [31:0] d;
    logic        sz;
    logic [31:0] exp_rd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One CSR request: drive at negedge, sample combinational outputs, commit at posedge.
  task automatic apply(input csr_op_t o, input logic [11:0] a, input logic [31:0] d,
                       input logic sz, output logic [31:0] rd, output logic ill);
    @(negedge clk);
    req_valid = 1'b1; csr_op = o; addr = a; wdata = d; src_zero = sz;
    #1;
    rd  = rdata;
    ill = illegal;
    @(posedge clk);
    #1;
    req_valid = 1'b0; csr_op = CsrNone; wdata = '0; src_zero = 1'b0;
  endtask

  task automatic read_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ill;
    apply(CsrRs, a, 32'h0, 1'b1, rd, ill);
    check({name, "_rd"}, rd, exp);
    check({name, "_ill"}, {31'b0, ill}, 32'h0);
  endtask

  task automatic write_csr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        ill;
    apply(CsrRw, a, d, 1'b0, rd, ill);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, prev;
    logic        ill;

    rst_n = 1'b0; req_valid = 1'b0; csr_op = CsrNone; src_zero = 1'b0; addr = '0;
    wdata = '0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
    mret = 1'b0; retire = 1'b0;
    do_reset();

    #1;
    check("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_redirect_pc", redirect_pc, 32'h0);
    check("rst_mtvec", mtvec, 32'h0000_0200);
    check("rst_mepc", mepc, 32'h0);

`ifdef CSR_COUNTERS_EN
    apply(CsrRs, CsrMcycle, 32'h0, 1'b1, prev, ill);
    check("mcycle_near_zero", {31'b0, (prev < 32'd8)}, 32'h1);
    apply(CsrRs, CsrMcycle, 32'h0, 1'b1, rd, ill);
    check("mcycle_step", rd, prev + 32'd1);
`endif

    vecs.push_back('{CsrRs,   12'h300, 32'h0,         1'b1, 32'h0000_1800, 1'b0});
    vecs.push_back('{CsrRs,   12'h301, 32'h0,         1'b1, 32'h4000_0100, 1'b0});
    vecs.push_back('{CsrRs,   12'h305, 32'h0,         1'b1, 32'h0000_0200, 1'b0});
    vecs.push_back('{CsrRw,   12'h340, 32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{CsrRs,   12'h340, 32'h0000_00F0, 1'b0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{CsrRc,   12'h340, 32'h0000_000F, 1'b0, 32'hDEAD_BEFF, 1'b0});
    vecs.push_back('{CsrRs,   12'h340, 32'h0,         1'b1, 32'hDEAD_BEF0, 1'b0});
    vecs.push_back('{CsrRs,   12'hF14, 32'h0,         1'b1, 32'h0000_0005, 1'b0});
    vecs.push_back('{CsrRw,   12'hF14, 32'h0000_1234, 1'b0, 32'h0,         1'b1});
    vecs.push_back('{CsrRs,   12'h7FF, 32'h0,         1'b1, 32'h0,         1'b1});
    vecs.push_back('{CsrRw,   12'h7FF, 32'h1,         1'b0, 32'h0,         1'b1});
    vecs.push_back('{CsrNone, 12'h7FF, 32'h0,         1'b0, 32'h0,         1'b1});
    vecs.push_back('{CsrRs,   12'hF14, 32'h0,         1'b1, 32'h0000_0005, 1'b0});
    vecs.push_back('{CsrRw,   12'h301, 32'h0,         1'b0, 32'h4000_0100, 1'b0});
    vecs.push_back('{CsrRs,   12'h301, 32'h0,         1'b1, 32'h4000_0100, 1'b0});
    vecs.push_back('{CsrRs,   12'h344, 32'h1,         1'b0, 32'h0,         1'b0});
    vecs.push_back('{CsrRw,   12'h305, 32'h0000_1003, 1'b0, 32'h0000_0200, 1'b0});
    vecs.push_back('{CsrRs,   12'h305, 32'h0,         1'b1, 32'h0000_1000, 1'b0});
    vecs.push_back('{CsrRw,   12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0000_1800, 1'b0});
    vecs.push_back('{CsrRc,   12'h300, 32'h0000_0008, 1'b0, 32'h0000_1888, 1'b0});
    vecs.push_back('{CsrRs,   12'h300, 32'h0,         1'b1, 32'h0000_1880, 1'b0});
    vecs.push_back('{CsrRw,   12'h304, 32'h0000_0888, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{CsrRs,   12'h304, 32'h0,         1'b1, 32'h0000_0888, 1'b0});
    vecs.push_back('{CsrRw,   12'h341, 32'h0000_0123, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{CsrRs,   12'h341, 32'h0,         1'b1, 32'h0000_0120, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].sz, rd, ill);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_illegal", i), {31'b0, ill}, {31'b0, vecs[i].exp_ill});
    end
    check("mtvec_out", mtvec, 32'h0000_1000);

    // Trap entry with MIE set.
    write_csr(CsrMstatus, 32'h0000_0008);
    read_csr("mstatus_mie1", CsrMstatus, 32'h0000_1808);
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h100; trap_tval = 32'h55;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    @(negedge clk);
    check("trap_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check("trap_busy", {31'b0, busy}, 32'h1);
    check("trap_redirect_pc", redirect_pc, 32'h0000_1000);
    check("trap_mepc", mepc, 32'h100);
    @(negedge clk);
    check("trap_redirect_done", {31'b0, redirect_valid}, 32'h0);
    read_csr("trap_mstatus", CsrMstatus, 32'h0000_1880);
    read_csr("trap_mcause", CsrMcause, 32'd2);
    read_csr("trap_mtval", CsrMtval, 32'h55);

    // mret back to mepc.
    @(negedge clk);
    mret = 1'b1;
    @(posedge clk); #1;
    mret = 1'b0;
    @(negedge clk);
    check("mret_redirect_valid", {31'b0, redirect_valid}, 32'h1);
    check("mret_redirect_pc", redirect_pc, 32'h100);
    read_csr("mret_mstatus", CsrMstatus, 32'h0000_1888);

    // trap + mret + CSR write together: only the trap takes effect.
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = 32'd3; trap_pc = 32'h200; trap_tval = 32'h0;
    mret = 1'b1; req_valid = 1'b1; csr_op = CsrRw; addr = CsrMscratch; wdata = 32'h1111;
    @(posedge clk); #1;
    trap_valid = 1'b0; mret = 1'b0;
    wdata = 32'h2222;
    @(negedge clk);
    check("prio_redirect_pc", redirect_pc, 32'h0000_1000);
    check("prio_mepc", mepc, 32'h200);
    @(posedge clk); #1;
    req_valid = 1'b0; csr_op = CsrNone; wdata = '0;
    read_csr("prio_mscratch", CsrMscratch, 32'hDEAD_BEF0);
    read_csr("prio_mstatus", CsrMstatus, 32'h0000_1880);
    read_csr("prio_mcause", CsrMcause, 32'd3);

    // Counters.
`ifdef CSR_COUNTERS_EN
    write_csr(CsrMcycle, 32'hFFFF_FFFF);
    write_csr(CsrMcycleh, 32'hFFFF_FFFF);
    read_csr("mcycle_allones", CsrMcycle, 32'hFFFF_FFFF);
    read_csr("mcycleh_wrapped", CsrMcycleh, 32'h0);
    @(negedge clk);
    retire = 1'b1; req_valid = 1'b1; csr_op = CsrRw; addr = CsrMinstret; wdata = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0; csr_op = CsrNone; wdata = '0;
    @(posedge clk); #1;
    retire = 1'b0;
    read_csr("minstret_after_retire", CsrMinstret, 32'd6);
`else
    write_csr(CsrMcycle, 32'h0000_1234);
    read_csr("mcycle_disabled", CsrMcycle, 32'h0);
    @(negedge clk);
    retire = 1'b1;
    @(posedge clk); #1;
    retire = 1'b0;
    read_csr("minstret_disabled", CsrMinstret, 32'h0);
`endif

    // Reset during a redirect aborts it and restores reset values.
    @(negedge clk);
    trap_valid = 1'b1; trap_pc = 32'h300;
    @(posedge clk); #1;
    trap_valid = 1'b0;
    @(negedge clk);
    check("abort_redirect_valid_pre", {31'b0, redirect_valid}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check("abort_redirect_pc", redirect_pc, 32'h0);
    check("abort_mepc", mepc, 32'h0);
    check("abort_mtvec", mtvec, 32'h0000_0200);
    read_csr("abort_mstatus", CsrMstatus, 32'h0000_1800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
